// File: rtl/usb_rx_pkt_decoder.sv
// usb_rx_pkt_decoder
//   Receive-side packet decoder between a UTMI RX interface and the protocol
//   engine. It checks the PID, splits packets into token / data / handshake
//   classes, strips the trailing CRC16 from DATA payloads through a 2-byte
//   delay line, and reports one status word per packet.
//
//   Ports
//     clk, rst_n          UTMI clock, asynchronous active-low reset
//     utmi_rx_*           UTMI receive byte stream (cannot be stalled)
//     dev_addr_cfg        assigned device address for token filtering
//     out_data/out_valid  payload bytes, CRC removed, one cycle per byte
//     pkt_start           pulse the cycle after a PID is accepted
//     pkt_end             pulse at end of packet; qualifies pkt_status/pkt_len
//     pkt_pid             last accepted PID
//     tok_addr/tok_endp   token fields (SOF: frame[6:0] / frame[10:7])
//     pkt_len             payload bytes delivered (saturating)
//     pkt_status          0 OK 1 PID_ERR 2 CRC_ERR 3 BABBLE 4 PHY_ERR
//                         5 ADDR_MISS 6 TRUNC
//
//   Optional build macro USB_RX_STATS_EN adds stat_clr and three saturating
//   16-bit packet counters (OK / CRC error / any other error).
module usb_rx_pkt_decoder #(
    parameter int MAX_PKT_BYTES = 1024,
    parameter int LEN_W         = 11,
    parameter bit ADDR_FILTER   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       utmi_rx_data,
    input  logic             utmi_rx_valid,
    input  logic             utmi_rx_active,
    input  logic             utmi_rx_error,
    input  logic [6:0]       dev_addr_cfg,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             pkt_start,
    output logic             pkt_end,
    output logic [3:0]       pkt_pid,
    output logic [6:0]       tok_addr,
    output logic [3:0]       tok_endp,
    output logic [LEN_W-1:0] pkt_len,
    output logic [2:0]       pkt_status
`ifdef USB_RX_STATS_EN
   ,input  logic             stat_clr,
    output logic [15:0]      stat_ok_cnt,
    output logic [15:0]      stat_crc_err_cnt,
    output logic [15:0]      stat_other_err_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_DATA, S_HS, S_DRAIN} state_t;

    localparam logic [2:0] ST_OK     = 3'd0;
    localparam logic [2:0] ST_PID    = 3'd1;
    localparam logic [2:0] ST_CRC    = 3'd2;
    localparam logic [2:0] ST_BABBLE = 3'd3;
    localparam logic [2:0] ST_PHY    = 3'd4;
    localparam logic [2:0] ST_MISS   = 3'd5;
    localparam logic [2:0] ST_TRUNC  = 3'd6;

    localparam logic [LEN_W:0]   CNT2       = (LEN_W+1)'(2);
    localparam logic [LEN_W:0]   CNT3       = (LEN_W+1)'(3);
    // Index of the first post-PID byte that no longer fits payload + CRC.
    localparam logic [LEN_W:0]   BABBLE_CNT = (LEN_W+1)'(MAX_PKT_BYTES + 2);
    localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_PKT_BYTES);

    // Reflected CRCs, LSB-first, right-shifting.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 5'h14 : 5'h00);
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'hA001 : 16'h0000);
        return r;
    endfunction

    state_t         state;
    logic [7:0]     pid_q;
    logic [7:0]     b1_q;
    logic [LEN_W:0] bcnt;       // post-PID bytes taken in this packet
    logic [4:0]     crc5;
    logic [15:0]    crc16;
    logic [7:0]     dl0, dl1;   // delay line, dl1 is the older byte
    logic           hs_extra;
    logic [2:0]     err_st;     // status carried through DRAIN

    logic           pid_ok;
    state_t         cur;
    logic [2:0]     drain_st, tok_st, data_st;

    assign pid_ok = (pid_q[7:4] == ~pid_q[3:0]);

    // In S_PID the byte stream may already carry the first post-PID byte, so
    // that cycle is processed as if already in the class state the PID selects.
    // Reserved/special PIDs (0, PRE/ERR, SPLIT) are handled like handshakes.
    always_comb begin
        cur = state;
        if (state == S_PID) begin
            if (!pid_ok) cur = S_DRAIN;
            else begin
                case (pid_q[3:0])
                    4'h1, 4'h9, 4'hD, 4'h5, 4'h4: cur = S_TOKEN;
                    4'h3, 4'hB, 4'h7, 4'hF:       cur = S_DATA;
                    default:                      cur = S_HS;
                endcase
            end
        end
    end

    always_comb begin
        drain_st = (state == S_PID) ? ST_PID : err_st;

        tok_st = ST_OK;
        if (bcnt != CNT2)
            tok_st = ST_TRUNC;
        else if (crc5 != 5'h06)
            tok_st = ST_CRC;
        else if (ADDR_FILTER && pid_q[3:0] != 4'h5 && tok_addr != dev_addr_cfg)
            tok_st = ST_MISS;

        data_st = ST_OK;
        if (bcnt < CNT2)
            data_st = ST_TRUNC;
        else if (crc16 != 16'hB001)
            data_st = ST_CRC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pid_q      <= '0;
            b1_q       <= '0;
            bcnt       <= '0;
            crc5       <= 5'h1F;
            crc16      <= 16'hFFFF;
            dl0        <= '0;
            dl1        <= '0;
            hs_extra   <= 1'b0;
            err_st     <= ST_OK;
            out_data   <= '0;
            out_valid  <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_end    <= 1'b0;
            pkt_pid    <= '0;
            tok_addr   <= '0;
            tok_endp   <= '0;
            pkt_len    <= '0;
            pkt_status <= '0;
        end else begin
            out_valid <= 1'b0;
            pkt_start <= 1'b0;
            pkt_end   <= 1'b0;
            if (state == S_IDLE) begin
                if (utmi_rx_valid && utmi_rx_active) begin
                    state    <= S_PID;
                    pid_q    <= utmi_rx_data;
                    bcnt     <= '0;
                    crc5     <= 5'h1F;
                    crc16    <= 16'hFFFF;
                    hs_extra <= 1'b0;
                    err_st   <= ST_OK;
                    pkt_len  <= '0;
                end
            end else begin
                if (state == S_PID && pid_ok) begin
                    pkt_pid   <= pid_q[3:0];
                    pkt_start <= 1'b1;
                end
                if (utmi_rx_error) begin
                    // PHY error outranks everything; the byte is discarded.
                    err_st <= ST_PHY;
                    state  <= S_DRAIN;
                end else if (!utmi_rx_active) begin
                    pkt_end <= 1'b1;
                    state   <= S_IDLE;
                    case (cur)
                        S_TOKEN: pkt_status <= tok_st;
                        S_DATA:  pkt_status <= data_st;
                        S_HS:    pkt_status <= hs_extra ? ST_TRUNC : ST_OK;
                        default: pkt_status <= drain_st;
                    endcase
                end else begin
                    state <= cur;
                    if (cur == S_DRAIN) err_st <= drain_st;
                    if (utmi_rx_valid) begin
                        case (cur)
                            S_TOKEN: begin
                                if (bcnt == '0) b1_q <= utmi_rx_data;
                                if (bcnt == (LEN_W+1)'(1)) begin
                                    tok_addr <= b1_q[6:0];
                                    tok_endp <= {utmi_rx_data[2:0], b1_q[7]};
                                end
                                if (bcnt < CNT2) crc5 <= crc5_byte(crc5, utmi_rx_data);
                                if (bcnt < CNT3) bcnt <= bcnt + 1'b1;
                            end
                            S_DATA: begin
                                if (bcnt == BABBLE_CNT) begin
                                    err_st <= ST_BABBLE;
                                    state  <= S_DRAIN;
                                end else begin
                                    crc16 <= crc16_byte(crc16, utmi_rx_data);
                                    dl0   <= utmi_rx_data;
                                    dl1   <= dl0;
                                    bcnt  <= bcnt + 1'b1;
                                    // Only a byte pushed out by a third byte is
                                    // payload; the last two are the CRC.
                                    if (bcnt >= CNT2) begin
                                        out_data  <= dl1;
                                        out_valid <= 1'b1;
                                        if (pkt_len != LEN_MAX) pkt_len <= pkt_len + 1'b1;
                                    end
                                end
                            end
                            S_HS:    hs_extra <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

`ifdef USB_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ok_cnt        <= '0;
            stat_crc_err_cnt   <= '0;
            stat_other_err_cnt <= '0;
        end else if (stat_clr) begin
            stat_ok_cnt        <= '0;
            stat_crc_err_cnt   <= '0;
            stat_other_err_cnt <= '0;
        end else if (pkt_end) begin
            case (pkt_status)
                ST_OK:   if (stat_ok_cnt != 16'hFFFF) stat_ok_cnt <= stat_ok_cnt + 1'b1;
                ST_CRC:  if (stat_crc_err_cnt != 16'hFFFF) stat_crc_err_cnt <= stat_crc_err_cnt + 1'b1;
                default: if (stat_other_err_cnt != 16'hFFFF) stat_other_err_cnt <= stat_other_err_cnt + 1'b1;
            endcase
        end
    end
`else
    // Statistics disabled: pkt_end/pkt_status are the only packet summary.
`endif

endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// Bench for usb_rx_pkt_decoder (MAX_PKT_BYTES=8 so babble is reachable).
// A packet-level model turns each driven packet into expected payload bytes
// and an end-of-packet record; a per-cycle monitor compares the DUT with them.
module tb_usb_rx_pkt_decoder;
    localparam int MAXB = 8;
    localparam int LW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    utmi_rx_data = '0;
    logic          utmi_rx_valid = 1'b0, utmi_rx_active = 1'b0, utmi_rx_error = 1'b0;
    logic [6:0]    dev_addr_cfg = '0;
    logic [7:0]    out_data;
    logic          out_valid, pkt_start, pkt_end;
    logic [3:0]    pkt_pid, tok_endp;
    logic [6:0]    tok_addr;
    logic [LW-1:0] pkt_len;
    logic [2:0]    pkt_status;

    always #5 clk = ~clk;

    usb_rx_pkt_decoder #(.MAX_PKT_BYTES(MAXB), .LEN_W(LW), .ADDR_FILTER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .utmi_rx_data(utmi_rx_data), .utmi_rx_valid(utmi_rx_valid),
        .utmi_rx_active(utmi_rx_active), .utmi_rx_error(utmi_rx_error), .dev_addr_cfg(dev_addr_cfg),
        .out_data(out_data), .out_valid(out_valid), .pkt_start(pkt_start), .pkt_end(pkt_end),
        .pkt_pid(pkt_pid), .tok_addr(tok_addr), .tok_endp(tok_endp), .pkt_len(pkt_len),
        .pkt_status(pkt_status));

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [2:0]    st;
        logic [3:0]    pid;
        logic [LW-1:0] len;
        logic [6:0]    addr;
        logic [3:0]    endp;
    } rec_t;

    logic [7:0] exp_q[$];
    rec_t       rec_q[$];
    int checks = 0, failures = 0;
    logic [3:0] m_pid = '0;
    logic [6:0] m_addr = '0;
    logic [3:0] m_endp = '0;
    int m_starts = 0, d_starts = 0, out_cnt = 0;
    rec_t last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] crc5_bits(input logic [15:0] v, input int nbits);
        logic [4:0] c;
        bit fb;
        c = 5'h1F;
        for (int i = 0; i < nbits; i++) begin
            fb = c[0] ^ v[i];
            c = c >> 1;
            if (fb) c = c ^ 5'h14;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_q(input bq_t b, input int from, input int to);
        logic [15:0] c;
        bit fb;
        c = 16'hFFFF;
        for (int j = from; j <= to; j++)
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ b[j][i];
                c = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        return c;
    endfunction

    function automatic bit is_tok(input logic [3:0] p);
        return (p == 4'h1) || (p == 4'h9) || (p == 4'hD) || (p == 4'h5) || (p == 4'h4);
    endfunction

    function automatic bit is_data(input logic [3:0] p);
        return (p == 4'h3) || (p == 4'hB) || (p == 4'h7) || (p == 4'hF);
    endfunction

    // Expected outcome of one packet; k>0 means utmi_rx_error on post-PID byte k.
    task automatic model_pkt(input bq_t b, input int k, input logic [6:0] addr, output int st);
        int n, np, em;
        logic [3:0] p;
        rec_t r;
        n  = b.size() - 1;
        np = (k > 0) ? k - 1 : n;
        p  = b[0][3:0];
        em = 0;
        if (b[0][7:4] != ~p) st = 1;
        else begin
            m_pid = p;
            m_starts++;
            if (is_tok(p)) begin
                if (np >= 2) begin
                    m_addr = b[1][6:0];
                    m_endp = {b[2][2:0], b[1][7]};
                end
                if (n != 2) st = 6;
                else if (crc5_bits({b[2], b[1]}, 16) != 5'h06) st = 2;
                else if (p != 4'h5 && b[1][6:0] != addr) st = 5;
                else st = 0;
            end else if (is_data(p)) begin
                em = np - 2;
                if (em < 0) em = 0;
                if (em > MAXB) em = MAXB;
                for (int i = 1; i <= em; i++) exp_q.push_back(b[i]);
                if (np >= MAXB + 3) st = 3;
                else if (n < 2) st = 6;
                else if (crc16_q(b, 1, n) != 16'hB001) st = 2;
                else st = 0;
            end else st = (n > 0) ? 6 : 0;
            if (k > 0) st = 4;
        end
        r.st = 3'(st); r.pid = m_pid; r.len = LW'(em); r.addr = m_addr; r.endp = m_endp;
        rec_q.push_back(r);
    endtask

    // One bench cycle: compare at the falling edge, then step past the rising edge.
    task automatic tick;
        rec_t r;
        logic [7:0] e;
        @(negedge clk);
        if (pkt_start) d_starts++;
        if (out_valid) begin
            out_cnt++;
            chk("out_valid_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", int'(out_data), int'(e));
            end
        end
        if (pkt_end) begin
            last = {pkt_status, pkt_pid, pkt_len, tok_addr, tok_endp};
            chk("pkt_end_expected", int'(rec_q.size() != 0), 1);
            if (rec_q.size() != 0) begin
                r = rec_q.pop_front();
                chk("pkt_status", int'(pkt_status), int'(r.st));
                chk("pkt_pid", int'(pkt_pid), int'(r.pid));
                chk("pkt_len", int'(pkt_len), int'(r.len));
                chk("tok_addr", int'(tok_addr), int'(r.addr));
                chk("tok_endp", int'(tok_endp), int'(r.endp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input bq_t b, input int k, input logic [6:0] addr, input int max_gap,
                            input int gap_after, input bit use_model, output int st);
        st = 0;
        dev_addr_cfg = addr;
        if (use_model) model_pkt(b, k, addr, st);
        for (int i = 0; i < b.size(); i++) begin
            utmi_rx_active = 1'b1;
            utmi_rx_valid  = 1'b1;
            utmi_rx_data   = b[i];
            utmi_rx_error  = (k > 0 && i == k);
            tick();
            utmi_rx_valid = 1'b0;
            utmi_rx_error = 1'b0;
            repeat ($urandom_range(0, max_gap)) tick();
        end
        utmi_rx_active = 1'b0;
        repeat (gap_after) tick();
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while ((rec_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", int'(rec_q.size() + exp_q.size()), 0);
    endtask

    task automatic dir(input string name, input bq_t b, input int k, input logic [6:0] addr,
                       input int est, input int elen, input int eouts);
        int st;
        out_cnt = 0;
        send_pkt(b, k, addr, 0, 1, 1'b1, st);
        wait_done();
        chk({name, "_model_status"}, st, est);
        chk({name, "_status"}, int'(last.st), est);
        chk({name, "_len"}, int'(last.len), elen);
        chk({name, "_outs"}, out_cnt, eouts);
    endtask

    function automatic bq_t mk_tok(input logic [3:0] p, input logic [6:0] a, input logic [3:0] ep);
        bq_t b;
        logic [15:0] v;
        logic [4:0] c;
        v = {5'h0, ep, a};
        c = ~crc5_bits(v, 11);
        b.push_back({~p, p});
        b.push_back(v[7:0]);
        b.push_back({c, v[10:8]});
        return b;
    endfunction

    function automatic bq_t mk_data(input logic [3:0] p, input int plen);
        bq_t b;
        logic [15:0] c;
        b.push_back({~p, p});
        for (int i = 0; i < plen; i++) b.push_back(8'($urandom));
        c = ~crc16_q(b, 1, plen);
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        return b;
    endfunction

    initial begin
        bq_t b, b2;
        int st, kind, k, n;
        logic [3:0] p;
        logic [6:0] a;
        logic [3:0] tokp[5] = '{4'h1, 4'h9, 4'hD, 4'h5, 4'h4};
        logic [3:0] datp[4] = '{4'h3, 4'hB, 4'h7, 4'hF};
        logic [3:0] hsp[7]  = '{4'h2, 4'hA, 4'hE, 4'h6, 4'h0, 4'h8, 4'hC};

        repeat (3) tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_pkt_end", int'(pkt_end), 0);
        chk("rst_pkt_start", int'(pkt_start), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_misc", int'({pkt_pid, tok_addr, tok_endp, pkt_len, pkt_status}), 0);
        rst_n = 1'b1;
        tick();

        b = '{8'h2D, 8'h00, 8'h10};
        dir("setup_ok", b, 0, 7'd0, 0, 0, 0);
        chk("setup_pid", int'(last.pid), 4'hD);
        chk("setup_addr_endp", int'({last.addr, last.endp}), 0);
        dir("setup_miss", b, 0, 7'd5, 5, 0, 0);
        b = '{8'h2D, 8'h00, 8'h11};
        dir("setup_crc", b, 0, 7'd0, 2, 0, 0);
        b = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        dir("data0_ok", b, 0, 7'd0, 0, 8, 8);
        b = '{8'h4B, 8'h00, 8'h00};
        dir("data1_empty", b, 0, 7'd0, 0, 0, 0);
        b = '{8'hD2};
        dir("ack", b, 0, 7'd0, 0, 0, 0);
        b = '{8'h12, 8'h34, 8'h56};
        dir("bad_pid", b, 0, 7'd0, 1, 0, 0);
        b = '{8'h4B, 8'h01};
        dir("data_trunc", b, 0, 7'd0, 6, 0, 0);
        b = '{8'hD2, 8'h00};
        dir("hs_extra", b, 0, 7'd0, 6, 0, 0);
        b = {8'hC3};
        for (int i = 0; i < 12; i++) b.push_back(8'(8'h10 + i));
        dir("babble", b, 0, 7'd0, 3, 8, 8);
        b = mk_data(4'h3, 6);
        dir("phy_err", b, 5, 7'd0, 4, 2, 2);

        // Back-to-back: a single idle cycle of utmi_rx_active between packets.
        out_cnt = 0;
        b  = mk_tok(4'h9, 7'h2A, 4'h3);
        b2 = mk_data(4'hB, 3);
        send_pkt(b, 0, 7'h2A, 0, 1, 1'b1, st);
        send_pkt(b2, 0, 7'h2A, 0, 1, 1'b1, st);
        wait_done();
        chk("b2b_status", int'(last.st), 0);
        chk("b2b_tok", int'({last.addr, last.endp}), int'({7'h2A, 4'h3}));
        chk("b2b_outs", out_cnt, 3);

        for (int t = 0; t < 120; t++) begin
            kind = $urandom_range(0, 9);
            a = 7'($urandom);
            k = 0;
            if (kind <= 3) begin
                p = tokp[$urandom_range(0, 4)];
                b = mk_tok(p, ($urandom_range(0, 1) == 1) ? a : 7'($urandom), 4'($urandom));
                if ($urandom_range(0, 6) == 0) void'(b.pop_back());
                else if ($urandom_range(0, 6) == 0) b.push_back(8'($urandom));
            end else if (kind <= 6) begin
                b = mk_data(datp[$urandom_range(0, 3)], $urandom_range(0, 10));
                if ($urandom_range(0, 9) == 0) while (b.size() > 1 + $urandom_range(0, 1)) void'(b.pop_back());
            end else if (kind <= 8) begin
                p = hsp[$urandom_range(0, 6)];
                b = '{{~p, p}};
                if ($urandom_range(0, 4) == 0) b.push_back(8'($urandom));
            end else begin
                p = 4'($urandom);
                b = '{{~p ^ 4'($urandom_range(1, 15)), p}};
                repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
            end
            n = b.size() - 1;
            if (kind <= 6 && n >= 1 && $urandom_range(0, 5) == 0) b[n] = b[n] ^ 8'h01;
            if (kind <= 8 && n >= 1 && $urandom_range(0, 6) == 0) k = $urandom_range(1, n);
            send_pkt(b, k, a, 2, $urandom_range(1, 3), 1'b1, st);
        end
        wait_done();

        // Reset in the middle of a DATA packet: no pkt_end may follow.
        b = '{8'hC3, 8'h11, 8'h22};
        m_starts++;
        utmi_rx_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            utmi_rx_valid = 1'b1;
            utmi_rx_data  = b[i];
            tick();
        end
        utmi_rx_valid = 1'b0;
        rst_n = 1'b0;
        m_pid = '0; m_addr = '0; m_endp = '0;
        #1;
        chk("midrst_clear", int'({out_valid, pkt_end, pkt_pid, tok_addr, pkt_len, pkt_status}), 0);
        utmi_rx_active = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        b = '{8'h5A};
        dir("after_rst_nak", b, 0, 7'd0, 0, 0, 0);
        chk("after_rst_pid", int'(last.pid), 4'hA);
        chk("pkt_start_count", d_starts, m_starts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
